// File: rtl/geofence_driver_if.sv
// Signal bundle between the geofence driver and its environment:
// point-memory read port, point stream / result from geofence, result write port.
interface geofence_driver_if;
   logic        mem_rd;
   logic [10:0] mem_addr;
   logic        mem_gnt;
   logic [19:0] mem_data;

   logic [9:0]  X;
   logic [9:0]  Y;
   logic        dut_rst;
   logic        valid;
   logic        is_inside;

   logic        res_we;
   logic [7:0]  res_addr;
   logic        res_data;
   logic        res_err;

   modport master (
      output mem_rd, mem_addr, X, Y, dut_rst, res_we, res_addr, res_data, res_err,
      input  mem_gnt, mem_data, valid, is_inside
   );

   modport slave (
      input  mem_rd, mem_addr, X, Y, dut_rst, res_we, res_addr, res_data, res_err,
      output mem_gnt, mem_data, valid, is_inside
   );
endinterface

// File: rtl/geofence_driver.sv
// Batch driver for a geofence core: fetches 7-point objects into ping-pong
// buffers, streams them out, and records one result (or timeout) per object.
//
// state | meaning
// IDLE  | waiting for start, core held in reset
// LOAD  | filling the first buffer with object 0, core held in reset
// SEND  | streaming points 0..6 of the current object, one per cycle
// WAIT  | waiting for valid from the core, bounded by TIMEOUT
// HOLD  | result written, next object not yet buffered (or last object done)
// FIN   | one-cycle done pulse
module geofence_driver #(
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [7:0]        num_obj,
   output logic              busy,
   output logic              done,
   geofence_driver_if.master gf
);

   typedef enum logic [2:0] {IDLE, LOAD, SEND, WAIT, HOLD, FIN} state_t;

   localparam logic [15:0] TO_CNT = 16'(TIMEOUT);

   state_t      state_q, state_d;
   logic [7:0]  obj_q, obj_d;
   logic [7:0]  num_q, num_d;
   logic        send_sel_q, send_sel_d;
   logic [2:0]  send_cnt_q, send_cnt_d;
   logic [15:0] wait_cnt_q, wait_cnt_d;
   logic        res_we_q, res_we_d;
   logic [7:0]  res_addr_q, res_addr_d;
   logic        res_data_q, res_data_d;
   logic        res_err_q, res_err_d;

   logic        fetch_busy_q, fetch_busy_d;
   logic [2:0]  rd_idx_q, rd_idx_d;
   logic [10:0] fetch_base_q, fetch_base_d;
   logic        fill_sel_q, fill_sel_d;
   logic        cap_vld_q, cap_vld_d;
   logic [2:0]  cap_idx_q, cap_idx_d;
   logic [1:0]  full_q, full_d;

   logic [19:0] pp_q [2][7];

   logic        fetch_go;
   logic [7:0]  fetch_obj;
   logic        fetch_sel;
   logic        advance;
   logic        accept;
   logic        last_cap;
   logic        cur_full;
   logic        nxt_full;
   logic        has_next;
   logic        has_next2;
   logic [8:0]  obj_p1;
   logic [10:0] fetch_obj_w;
   logic [19:0] pt_out;

   assign accept   = fetch_busy_q & gf.mem_gnt;
   assign last_cap = cap_vld_q & (cap_idx_q == 3'd6);
   // A buffer counts as full in the cycle its last entry is being captured.
   assign cur_full = full_q[send_sel_q]  | (last_cap & (fill_sel_q == send_sel_q));
   assign nxt_full = full_q[~send_sel_q] | (last_cap & (fill_sel_q != send_sel_q));

   assign obj_p1    = {1'b0, obj_q} + 9'd1;
   assign has_next  = obj_p1 < {1'b0, num_q};
   assign has_next2 = (obj_p1 + 9'd1) < {1'b0, num_q};

   assign fetch_obj_w = {3'b000, fetch_obj};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         obj_q        <= '0;
         num_q        <= '0;
         send_sel_q   <= 1'b0;
         send_cnt_q   <= '0;
         wait_cnt_q   <= '0;
         res_we_q     <= 1'b0;
         res_addr_q   <= '0;
         res_data_q   <= 1'b0;
         res_err_q    <= 1'b0;
         fetch_busy_q <= 1'b0;
         rd_idx_q     <= '0;
         fetch_base_q <= '0;
         fill_sel_q   <= 1'b0;
         cap_vld_q    <= 1'b0;
         cap_idx_q    <= '0;
         full_q       <= '0;
      end else begin
         state_q      <= state_d;
         obj_q        <= obj_d;
         num_q        <= num_d;
         send_sel_q   <= send_sel_d;
         send_cnt_q   <= send_cnt_d;
         wait_cnt_q   <= wait_cnt_d;
         res_we_q     <= res_we_d;
         res_addr_q   <= res_addr_d;
         res_data_q   <= res_data_d;
         res_err_q    <= res_err_d;
         fetch_busy_q <= fetch_busy_d;
         rd_idx_q     <= rd_idx_d;
         fetch_base_q <= fetch_base_d;
         fill_sel_q   <= fill_sel_d;
         cap_vld_q    <= cap_vld_d;
         cap_idx_q    <= cap_idx_d;
         full_q       <= full_d;
      end
   end

   // Buffer storage needs no reset: the full flags gate every use of it.
   always_ff @(posedge clk) begin
      if (cap_vld_q) begin
         pp_q[fill_sel_q][cap_idx_q] <= gf.mem_data;
      end
   end

   always_comb begin
      state_d    = state_q;
      obj_d      = obj_q;
      num_d      = num_q;
      send_sel_d = send_sel_q;
      send_cnt_d = send_cnt_q;
      wait_cnt_d = wait_cnt_q;
      res_we_d   = 1'b0;
      res_addr_d = '0;
      res_data_d = 1'b0;
      res_err_d  = 1'b0;
      fetch_go   = 1'b0;
      fetch_obj  = '0;
      fetch_sel  = 1'b0;
      advance    = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               num_d      = num_obj;
               obj_d      = '0;
               send_sel_d = 1'b0;
               if (num_obj == 8'd0) begin
                  state_d = FIN;
               end else begin
                  state_d   = LOAD;
                  fetch_go  = 1'b1;
                  fetch_obj = '0;
                  fetch_sel = 1'b0;
               end
            end
         end
         LOAD: begin
            if (cur_full) begin
               state_d    = SEND;
               send_cnt_d = '0;
               if (has_next) begin
                  fetch_go  = 1'b1;
                  fetch_obj = obj_q + 8'd1;
                  fetch_sel = ~send_sel_q;
               end
            end
         end
         SEND: begin
            send_cnt_d = send_cnt_q + 3'd1;
            if (send_cnt_q == 3'd6) begin
               state_d    = WAIT;
               wait_cnt_d = 16'd1;
            end
         end
         WAIT: begin
            wait_cnt_d = wait_cnt_q + 16'd1;
            if (gf.valid) begin
               res_we_d   = 1'b1;
               res_addr_d = obj_q;
               res_data_d = gf.is_inside;
               if (has_next && nxt_full) begin
                  advance = 1'b1;
               end else begin
                  state_d = HOLD;
               end
            end else if (wait_cnt_q == TO_CNT) begin
               res_we_d   = 1'b1;
               res_addr_d = obj_q;
               res_err_d  = 1'b1;
               state_d    = HOLD;
            end
         end
         HOLD: begin
            if (!has_next) begin
               state_d = FIN;
            end else if (nxt_full) begin
               advance = 1'b1;
            end
         end
         FIN: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Switch to the prefetched buffer and refill the one just sent.
      if (advance) begin
         state_d    = SEND;
         obj_d      = obj_q + 8'd1;
         send_sel_d = ~send_sel_q;
         send_cnt_d = '0;
         if (has_next2) begin
            fetch_go  = 1'b1;
            fetch_obj = obj_q + 8'd2;
            fetch_sel = send_sel_q;
         end
      end
   end

   always_comb begin
      fetch_busy_d = fetch_busy_q;
      rd_idx_d     = rd_idx_q;
      fetch_base_d = fetch_base_q;
      fill_sel_d   = fill_sel_q;
      full_d       = full_q;
      cap_vld_d    = accept;
      cap_idx_d    = rd_idx_q;

      if (state_q == IDLE) begin
         full_d = 2'b00;
      end
      if (last_cap) begin
         full_d[fill_sel_q] = 1'b1;
      end
      if (fetch_go) begin
         fetch_busy_d       = 1'b1;
         rd_idx_d           = '0;
         fetch_base_d       = (fetch_obj_w << 3) - fetch_obj_w;
         fill_sel_d         = fetch_sel;
         full_d[fetch_sel]  = 1'b0;
      end else if (accept) begin
         rd_idx_d = rd_idx_q + 3'd1;
         if (rd_idx_q == 3'd6) begin
            fetch_busy_d = 1'b0;
         end
      end
   end

   assign pt_out = pp_q[send_sel_q][send_cnt_q];

   always_comb begin
      gf.X = '0;
      gf.Y = '0;
      if (state_q == SEND) begin
         gf.X = pt_out[19:10];
         gf.Y = pt_out[9:0];
      end
   end

   assign gf.mem_rd   = fetch_busy_q;
   assign gf.mem_addr = fetch_busy_q ? (fetch_base_q + {8'b0, rd_idx_q}) : 11'd0;
   assign gf.dut_rst  = !((state_q == SEND) || (state_q == WAIT));
   assign gf.res_we   = res_we_q;
   assign gf.res_addr = res_addr_q;
   assign gf.res_data = res_data_q;
   assign gf.res_err  = res_err_q;
   assign busy        = (state_q != IDLE);
   assign done        = (state_q == FIN);

endmodule

// File: tb/tb_geofence_driver.sv
// Scoreboard bench for geofence_driver: memory model, geofence model and
// result monitor check the DUT against hand-built point/result tables.
module tb_geofence_driver;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic [7:0] num_obj;
   logic       busy;
   logic       done;

   geofence_driver_if gf();

   geofence_driver #(.TIMEOUT(255)) dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .num_obj (num_obj),
      .busy    (busy),
      .done    (done),
      .gf      (gf)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   int n_vec = 0;
   int n_err = 0;
   int done_cnt = 0, done_cyc = 0, mem_rd_cnt = 0, n_res = 0, start_cyc = 0;
   int gf_cnt = 0, gf_left = -1, gf_obj = 0, valid_cyc = -1;
   int run_rst = 0, last_hold = 0, hold_max = 0;
   bit gap_chk = 0, stall_arm = 0;
   int dly [8];
   bit ins [8];
   logic [19:0] mem [2048];
   logic [19:0] exp_pt [$];
   logic [9:0]  exp_res [$];
   int res_cycs [$];
   int lp_cycs [$];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d", nm, act, act, exp, exp, cyc);
      end
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Point memory: grant decided by the stall controller, data one cycle after acceptance.
   initial begin
      logic acc;
      logic [10:0] a;
      gf.mem_data = '0;
      forever begin
         @(negedge clk);
         #4;
         acc = gf.mem_rd & gf.mem_gnt;
         a = gf.mem_addr;
         @(posedge clk);
         #1;
         gf.mem_data = acc ? mem[a] : 20'h0;
      end
   end

   initial begin
      gf.mem_gnt = 1'b1;
      forever begin
         @(negedge clk);
         if (stall_arm && !gf.dut_rst) begin
            gf.mem_gnt = 1'b0;
            stall_arm = 0;
            repeat (40) @(negedge clk);
            gf.mem_gnt = 1'b1;
         end
      end
   end

   // Geofence model: consumes 7 points per object, answers after dly[] cycles.
   initial begin
      logic [19:0] e;
      gf.valid = 1'b0;
      gf.is_inside = 1'b0;
      forever begin
         @(negedge clk);
         gf.valid = 1'b0;
         gf.is_inside = 1'b0;
         if (gf.dut_rst) begin
            if (gf_cnt == 7) gf_obj++;
            gf_cnt = 0;
            gf_left = -1;
            run_rst++;
         end else if (gf_cnt < 7) begin
            if (exp_pt.size() == 0) begin
               check("point_unexpected", {gf.X, gf.Y}, 20'h0);
            end else begin
               e = exp_pt.pop_front();
               check("point", {12'h0, gf.X, gf.Y}, {12'h0, e});
            end
            if (gf_cnt == 0 && gf_obj > 0) begin
               last_hold = run_rst;
               if (run_rst > hold_max) hold_max = run_rst;
               if (gap_chk && valid_cyc >= 0) check("valid_to_point0", cyc - valid_cyc, 1);
            end
            gf_cnt++;
            if (gf_cnt == 7) begin
               gf_left = dly[gf_obj];
               run_rst = 0;
               lp_cycs.push_back(cyc);
            end
         end else begin
            check("xy_idle", {gf.X, gf.Y}, 20'h0);
            if (gf_left > 0) begin
               gf_left--;
               if (gf_left == 0) begin
                  gf.valid = 1'b1;
                  gf.is_inside = ins[gf_obj];
                  valid_cyc = cyc;
                  gf_obj++;
                  gf_cnt = 0;
               end
            end
         end
      end
   end

   initial forever begin
      logic [9:0] e;
      @(negedge clk);
      if (gf.res_we) begin
         n_res++;
         res_cycs.push_back(cyc);
         if (exp_res.size() == 0) begin
            check("res_unexpected", {gf.res_addr, gf.res_data, gf.res_err}, 10'h3ff);
         end else begin
            e = exp_res.pop_front();
            check("result", {gf.res_addr, gf.res_data, gf.res_err}, e);
         end
      end
      if (done) begin
         done_cnt++;
         done_cyc = cyc;
      end
      if (gf.mem_rd) mem_rd_cnt++;
   end

   task automatic reset_state_check(input string tag);
      check({tag, "_mem"}, {gf.mem_rd, gf.mem_addr}, 0);
      check({tag, "_xy"}, {gf.X, gf.Y}, 0);
      check({tag, "_res"}, {gf.res_we, gf.res_addr, gf.res_data, gf.res_err}, 0);
      check({tag, "_stat"}, {busy, done, gf.dut_rst}, 3'b001);
   endtask

   task automatic prep();
      exp_pt.delete();
      exp_res.delete();
      res_cycs.delete();
      lp_cycs.delete();
      gf_obj = 0;
      valid_cyc = -1;
      hold_max = 0;
      last_hold = 0;
      gap_chk = 0;
      for (int i = 0; i < 8; i++) begin
         dly[i] = -1;
         ins[i] = 0;
      end
   endtask

   task automatic push_obj(input int k);
      for (int p = 0; p < 7; p++) exp_pt.push_back(mem[7*k + p]);
   endtask

   task automatic run_batch(input int n, input int budget, input bit spurious);
      int d0;
      bit seen;
      @(negedge clk);
      num_obj = 8'(n);
      start = 1'b1;
      start_cyc = cyc;
      d0 = done_cnt;
      @(negedge clk);
      start = 1'b0;
      check("busy_rise", busy, 1);
      seen = 0;
      for (int i = 0; i < budget; i++) begin
         if (spurious && i == 15) begin
            start = 1'b1;
            num_obj = 8'd5;
         end
         if (spurious && i == 16) start = 1'b0;
         @(negedge clk);
         if (done_cnt != d0) begin
            seen = 1;
            break;
         end
      end
      start = 1'b0;
      check("done_seen", seen, 1);
      repeat (3) @(negedge clk);
      check("idle_after", {busy, gf.dut_rst}, 2'b01);
      check("pts_left", exp_pt.size(), 0);
      check("res_left", exp_res.size(), 0);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1);
   end

   initial begin
      int r0, m0, d0;
      bit hit;
      reset = 1'b0;
      start = 1'b0;
      num_obj = '0;
      for (int i = 0; i < 2048; i++) mem[i] = '0;
      mem[0] = {10'd50, 10'd50};
      mem[1] = {10'd10, 10'd10};
      mem[2] = {10'd90, 10'd10};
      mem[3] = {10'd100, 10'd50};
      mem[4] = {10'd90, 10'd90};
      mem[5] = {10'd10, 10'd90};
      mem[6] = {10'd0, 10'd50};
      for (int k = 1; k < 4; k++)
         for (int p = 0; p < 7; p++)
            mem[7*k + p] = {10'(100 + 50*k + p), 10'(200 + 20*k + 7*p)};
      prep();

      repeat (3) @(negedge clk);
      reset_state_check("reset");
      reset = 1'b1;
      repeat (2) @(negedge clk);

      // Single object, answer 30 cycles after the last point.
      prep();
      dly[0] = 30; ins[0] = 1;
      push_obj(0);
      exp_res.push_back({8'd0, 1'b1, 1'b0});
      run_batch(1, 200, 0);
      if (res_cycs.size() > 0 && lp_cycs.size() > 0) begin
         check("a_valid_to_res", res_cycs[0] - lp_cycs[0], 31);
         check("a_res_to_done", done_cyc - res_cycs[0], 1);
      end else check("a_events", 0, 1);

      // Three objects back to back; a start mid-batch must be ignored.
      prep();
      dly[0] = 20; dly[1] = 20; dly[2] = 20;
      ins[0] = 1; ins[1] = 0; ins[2] = 1;
      gap_chk = 1;
      push_obj(0); push_obj(1); push_obj(2);
      exp_res.push_back({8'd0, 1'b1, 1'b0});
      exp_res.push_back({8'd1, 1'b0, 1'b0});
      exp_res.push_back({8'd2, 1'b1, 1'b0});
      run_batch(3, 400, 1);
      check("b_hold_max", hold_max, 0);
      check("b_nres", res_cycs.size(), 3);

      // Grant stalled 40 cycles from object 1's prefetch: core held until buffer fills.
      prep();
      dly[0] = 10; dly[1] = 20;
      ins[0] = 0; ins[1] = 1;
      push_obj(0); push_obj(1);
      exp_res.push_back({8'd0, 1'b0, 1'b0});
      exp_res.push_back({8'd1, 1'b1, 1'b0});
      stall_arm = 1;
      run_batch(2, 400, 0);
      check("c_hold_len", last_hold, 31);

      // No answer for object 0: timeout result, then object 1 normally.
      prep();
      dly[1] = 15; ins[1] = 1;
      push_obj(0); push_obj(1);
      exp_res.push_back({8'd0, 1'b0, 1'b1});
      exp_res.push_back({8'd1, 1'b1, 1'b0});
      run_batch(2, 800, 0);
      if (res_cycs.size() > 0 && lp_cycs.size() > 0)
         check("d_timeout_cycle", res_cycs[0] - lp_cycs[0], 256);
      else check("d_events", 0, 1);
      check("d_hold_min", last_hold >= 1, 1);

      // Empty batch.
      prep();
      m0 = mem_rd_cnt;
      r0 = n_res;
      run_batch(0, 10, 0);
      check("e_done_cycle", done_cyc - start_cyc, 1);
      check("e_no_rd", mem_rd_cnt - m0, 0);
      check("e_no_res", n_res - r0, 0);

      // Reset during SEND of object 1 aborts everything.
      prep();
      dly[0] = 5; ins[0] = 1;
      push_obj(0); push_obj(1);
      exp_res.push_back({8'd0, 1'b1, 1'b0});
      @(negedge clk);
      num_obj = 8'd2;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      hit = 0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (gf_obj == 1 && gf_cnt == 3) begin
            hit = 1;
            break;
         end
      end
      check("f_reach_obj1", hit, 1);
      reset = 1'b0;
      #1;
      reset_state_check("abort");
      exp_pt.delete();
      check("f_res_left", exp_res.size(), 0);
      repeat (3) @(negedge clk);
      r0 = n_res;
      m0 = mem_rd_cnt;
      d0 = done_cnt;
      reset = 1'b1;
      repeat (300) @(negedge clk);
      check("f_no_res", n_res - r0, 0);
      check("f_no_rd", mem_rd_cnt - m0, 0);
      check("f_no_done", done_cnt - d0, 0);
      check("f_quiet", {busy, gf.dut_rst}, 2'b01);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
